// File: rtl/triad_link_arbiter.sv
// triad_link_arbiter: round-robin share of one serial triad link among NCH peak-finder channels
// Ports: clock/reset_n (async, active-low); enable gates req capture; req/side per-channel
// peak pulse and half-strip bit; pending = occupied slots (channel output_busy);
// serial_out/frame_valid/frame_start = registered frame {1, channel, side}; drop_cnt = saturating drops.
module triad_link_arbiter #(
    parameter int NCH  = 8,
    parameter int GAP  = 1,
    parameter int CNTW = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            enable,
    input  logic [NCH-1:0]  req,
    input  logic [NCH-1:0]  side,
    output logic [NCH-1:0]  pending,
    output logic            serial_out,
    output logic            frame_valid,
    output logic            frame_start,
    output logic [CNTW-1:0] drop_cnt
);
    localparam int CHW = $clog2(NCH);
    localparam int FL = CHW + 2;
    localparam logic [CHW:0] LAST = (CHW+1)'(FL - 1);
    localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t          state, state_nx;
    logic [CHW-1:0]  ptr, ptr_nx, win;
    logic [CHW:0]    shreg, shreg_nx, cnt, cnt_nx;
    logic [3:0]      gcnt, gcnt_nx;
    logic [NCH-1:0]  slot_side, clr, acc, drop;
    logic [CNTW+5:0] dsum;
    logic            ser_nx, fv_nx, fs_nx, eval, grant;

    // first pending slot at or above ptr, wrapping; downward scan lets the nearest overwrite
    always_comb begin
        win = ptr;
        for (int i = NCH - 1; i >= 0; i--)
            if (pending[ptr + CHW'(i)]) win = ptr + CHW'(i);
    end

    // grant evaluation happens in IDLE, on the edge ending the gap, or straight after the side bit when GAP=0
    assign eval  = state == S_IDLE || (state == S_GAP && gcnt == 4'd0) || (state == S_SEND && cnt == LAST && GAP == 0);
    assign grant = eval && |pending;
    assign clr   = grant ? NCH'(1) << win : '0;
    // a slot cleared by this edge's grant accepts a new request instead of dropping it
    assign acc   = enable ? req & ~(pending & ~clr) : '0;
    assign drop  = enable ? req & pending & ~clr : '0;
    assign dsum  = (CNTW+6)'(drop_cnt) + (CNTW+6)'($countones(drop));

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        gcnt_nx  = gcnt;
        ser_nx   = 1'b0;
        fv_nx    = 1'b0;
        fs_nx    = 1'b0;
        if (grant) begin
            state_nx = S_SEND;
            ptr_nx   = win + CHW'(1);
            shreg_nx = {win, slot_side[win]};
            cnt_nx   = '0;
            ser_nx   = 1'b1;
            fv_nx    = 1'b1;
            fs_nx    = 1'b1;
        end else if (state == S_SEND && cnt != LAST) begin
            shreg_nx = shreg << 1;
            cnt_nx   = cnt + 1'b1;
            ser_nx   = shreg[CHW];
            fv_nx    = 1'b1;
        end else if (state == S_SEND && GAP > 0) begin
            state_nx = S_GAP;
            gcnt_nx  = GAP_LD;
        end else if (state == S_GAP && gcnt != 4'd0) begin
            gcnt_nx  = gcnt - 1'b1;
        end else begin
            state_nx = S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            shreg       <= '0;
            cnt         <= '0;
            gcnt        <= '0;
            serial_out  <= 1'b0;
            frame_valid <= 1'b0;
            frame_start <= 1'b0;
            pending     <= '0;
            slot_side   <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            shreg       <= shreg_nx;
            cnt         <= cnt_nx;
            gcnt        <= gcnt_nx;
            serial_out  <= ser_nx;
            frame_valid <= fv_nx;
            frame_start <= fs_nx;
            pending     <= (pending & ~clr) | acc;
            slot_side   <= (slot_side & ~acc) | (side & acc);
            drop_cnt    <= |dsum[CNTW+5:CNTW] ? '1 : dsum[CNTW-1:0];
        end
    end
endmodule

// File: tb/tb_triad_link_arbiter.sv
// tb_triad_link_arbiter: checks a GAP=1 and a GAP=0 arbiter against a timeline model of the link
module tb_triad_link_arbiter;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] side = '0;
    logic [7:0] pend_a, pend_b, drop_a, drop_b;
    logic       serial_a, fv_a, fs_a, serial_b, fv_b, fs_b;

    triad_link_arbiter #(.NCH(8), .GAP(1), .CNTW(8)) dut_a (
        .clock(clock), .reset_n(reset_n), .enable(enable), .req(req), .side(side),
        .pending(pend_a), .serial_out(serial_a), .frame_valid(fv_a), .frame_start(fs_a), .drop_cnt(drop_a)
    );
    triad_link_arbiter #(.NCH(8), .GAP(0), .CNTW(8)) dut_b (
        .clock(clock), .reset_n(reset_n), .enable(enable), .req(req), .side(side),
        .pending(pend_b), .serial_out(serial_b), .frame_valid(fv_b), .frame_start(fs_b), .drop_cnt(drop_b)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // model: slot contents plus, per link, the edge of the latest grant and the earliest edge the link is free
    int         edge_n = 0;
    int         e_last = 0;
    logic [7:0] m_pend[2], m_side[2];
    logic [4:0] m_f[2];
    int         m_ptr[2], m_nxt[2], m_g[2], m_drop[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0;
            m_side[m] = '0;
            m_f[m]    = '0;
            m_ptr[m]  = 0;
            m_nxt[m]  = 0;
            m_g[m]    = -1000;
            m_drop[m] = 0;
        end
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int m = 0; m < 2; m++) begin
                logic [7:0] clr;
                clr = '0;
                if (edge_n >= m_nxt[m] && m_pend[m] != 0) begin
                    int w;
                    w = -1;
                    for (int i = 0; i < 8; i++)
                        if (w < 0 && m_pend[m][(m_ptr[m] + i) % 8]) w = (m_ptr[m] + i) % 8;
                    clr[w]   = 1'b1;
                    m_f[m]   = {1'b1, 3'(w), m_side[m][w]};
                    m_g[m]   = edge_n;
                    m_nxt[m] = edge_n + 5 + (m == 0 ? 1 : 0);
                    m_ptr[m] = (w + 1) % 8;
                end
                m_pend[m] = m_pend[m] & ~clr;
                if (enable)
                    for (int i = 0; i < 8; i++)
                        if (req[i]) begin
                            if (m_pend[m][i]) begin
                                if (m_drop[m] < 255) m_drop[m]++;
                            end else begin
                                m_pend[m][i] = 1'b1;
                                m_side[m][i] = side[i];
                            end
                        end
            end
        end
        e_last = edge_n;
        edge_n++;
    endtask

    // {frame_valid, serial_out, frame_start} expected after the latest edge
    function automatic logic [2:0] exp_o(int m);
        int k;
        k = e_last - m_g[m];
        if (k < 0 || k > 4) return 3'b000;
        return {1'b1, m_f[m][4-k], k == 0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_out", {29'd0, fv_a, serial_a, fs_a}, {29'd0, exp_o(0)});
        chk("a_pend", {24'd0, pend_a}, {24'd0, m_pend[0]});
        chk("a_drop", {24'd0, drop_a}, m_drop[0]);
        chk("b_out", {29'd0, fv_b, serial_b, fs_b}, {29'd0, exp_o(1)});
        chk("b_pend", {24'd0, pend_b}, {24'd0, m_pend[1]});
        chk("b_drop", {24'd0, drop_b}, m_drop[1]);
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    // frames seen on the GAP=1 link, decoded as {start, channel, side}
    logic [4:0] mbits = '0;
    int         mcnt = 0;
    logic [4:0] mq[$];
    always @(negedge clock) begin
        if (!reset_n) mcnt = 0;
        else if (fv_a) begin
            mbits = {mbits[3:0], serial_a};
            mcnt  = fs_a ? 1 : mcnt + 1;
            if (mcnt == 5) mq.push_back(mbits);
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        req     = '0;
        side    = '0;
        model_reset();
        cyc();
        #2 reset_n = 1'b1;
        mq.delete();
    endtask

    logic [4:0] s, st;
    int first, last, vcnt;

    initial begin
        model_reset();
        do_reset();
        chk("reset_out", {29'd0, fv_a, serial_a, fs_a}, 32'd0);

        // single request on channel 5, side 1
        req = 8'h20; side = 8'h20;
        cyc();
        chk("t1_pend", {24'd0, pend_a}, 32'h20);
        req = '0; side = '0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            s[4-k] = serial_a;
            st[4-k] = fs_a;
            if (k == 0) chk("t1_pend_clr", {24'd0, pend_a}, 32'h0);
        end
        chk("t1_bits", {27'd0, s}, 32'b11011);
        chk("t1_start", {27'd0, st}, 32'b10000);
        cyc();
        chk("t1_gap", {30'd0, fv_a, serial_a}, 32'd0);

        // all channels at once
        do_reset();
        req = 8'hFF; side = 8'($urandom);
        cyc();
        req = '0;
        first = -1; last = -1;
        for (int c = 0; c < 60; c++) begin
            cyc();
            if (fs_a && first < 0) first = c;
            if (fv_a) last = c;
        end
        chk("t2_span", last - first + 1, 47);
        chk("t2_frames", mq.size(), 8);
        for (int i = 0; i < 8 && i < mq.size(); i++) chk("t2_order", {29'd0, mq[i][3:1]}, i);
        chk("t2_pend", {24'd0, pend_a}, 32'd0);
        chk("t2_drop", {24'd0, drop_a}, 32'd0);

        // fairness between channels 2 and 6
        do_reset();
        req = 8'h44;
        for (int c = 0; c < 40; c++) cyc();
        req = '0;
        for (int c = 0; c < 15; c++) cyc();
        for (int i = 0; i < 6 && i < mq.size(); i++) chk("t3_alt", {29'd0, mq[i][3:1]}, (i % 2 == 0) ? 2 : 6);
        chk("t3_count", mq.size() >= 6, 1);

        // drops while slot 3 waits behind channel 0
        do_reset();
        req = 8'h09; side = 8'h08;
        cyc();
        req = '0;
        cyc();
        req = 8'h08; side = '0;
        for (int c = 0; c < 3; c++) cyc();
        req = '0;
        for (int c = 0; c < 20; c++) cyc();
        chk("t4_drop3", {24'd0, drop_a}, 32'd3);
        chk("t4_frames", mq.size(), 2);
        if (mq.size() >= 2) chk("t4_side", {27'd0, mq[1]}, 32'b10111);
        req = 8'hFF;
        for (int c = 0; c < 60; c++) begin
            side = 8'($urandom);
            cyc();
        end
        req = '0;
        cyc();
        chk("t4_sat_a", {24'd0, drop_a}, 32'd255);
        chk("t4_sat_b", {24'd0, drop_b}, 32'd255);

        // asynchronous reset in the middle of a frame
        do_reset();
        req = 8'h07; side = 8'h07;
        cyc();
        cyc();
        req = '0;
        cyc();
        cyc();
        chk("t5_busy", {31'd0, fv_a}, 32'd1);
        chk("t5_drops", {24'd0, drop_a}, 32'd2);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("t5_async", {30'd0, fv_a, serial_a}, 32'd0);
        chk("t5_pend", {24'd0, pend_a}, 32'd0);
        chk("t5_drop", {24'd0, drop_a}, 32'd0);
        check_all();
        cyc();
        #2 reset_n = 1'b1;
        mq.delete();
        req = 8'h01; side = 8'h00;
        cyc();
        req = '0;
        for (int c = 0; c < 8; c++) cyc();
        chk("t5_frames", mq.size(), 1);
        if (mq.size() >= 1) chk("t5_frame", {27'd0, mq[0]}, 32'b10000);

        // enable low ignores req; GAP=0 link drains back-to-back
        do_reset();
        req = 8'h0C; side = 8'h04;
        cyc();
        enable = 1'b0; req = 8'h06;
        vcnt = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (fv_b) vcnt++;
            chk("t6_nopend", {31'd0, pend_a[1] | pend_b[1]}, 32'd0);
        end
        chk("t6_b2b", vcnt, 10);
        cyc();
        chk("t6_idle", {31'd0, fv_b}, 32'd0);
        chk("t6_nodrop", {24'd0, drop_b}, 32'd0);
        req = '0; enable = 1'b1;

        // random traffic with occasional reset
        for (int c = 0; c < 1500; c++) begin
            enable = $urandom_range(0, 9) != 0;
            req    = 8'($urandom & $urandom & $urandom);
            side   = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                model_reset();
            end else reset_n = 1'b1;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
